// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt controller: register offsets, CP0 vector width
// and the fixed source assignment of the timer and external lines.
package irq_ctrl_pkg;

    localparam logic [1:0] IRQ_PEND  = 2'd0;
    localparam logic [1:0] IRQ_MASK  = 2'd1;
    localparam logic [1:0] IRQ_MODE  = 2'd2;
    localparam logic [1:0] IRQ_CLAIM = 2'd3;

    localparam int HWINT_W = 6;

    localparam int SRC_TC0 = 0;
    localparam int SRC_TC1 = 1;
    localparam int SRC_EXT = 2;

    // CLAIM encodes a source as index+1 so that 0 can mean "nothing pending".
    function automatic logic [31:0] claim_code(input int idx);
        return 32'(idx + 1);
    endfunction

endpackage

// File: rtl/irq_src_cell.sv
// One interrupt source: optional two-flop synchroniser, previous-value flop and a
// pend flop that either tracks the line (level) or latches rising edges (edge).
module irq_src_cell
    import irq_ctrl_pkg::*;
#(
    parameter int SYNC = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_src,
    input  logic i_edge_mode,
    input  logic i_clr,
    output logic o_pend
);

    logic w_s;
    logic r_prev;
    logic r_pend;

    generate
        if (SYNC != 0) begin : g_sync
            logic r_sync1;
            logic r_sync2;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_sync1 <= 1'b0;
                    r_sync2 <= 1'b0;
                end else begin
                    r_sync1 <= i_src;
                    r_sync2 <= r_sync1;
                end
            end

            assign w_s = r_sync2;
        end else begin : g_nosync
            assign w_s = i_src;
        end
    endgenerate

    // In edge mode a new rising edge beats a software clear on the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_prev <= 1'b0;
            r_pend <= 1'b0;
        end else begin
            r_prev <= w_s;
            if (!i_edge_mode) begin
                r_pend <= w_s;
            end else if (w_s && !r_prev) begin
                r_pend <= 1'b1;
            end else if (i_clr) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign o_pend = r_pend;

endmodule

// File: rtl/irq_ctrl.sv
// Word-addressed interrupt controller: per-source cells plus MASK/MODE registers,
// lowest-index-first CLAIM encoder and the 6-bit hardware-interrupt vector for CP0.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int N_SRC = 3,
    parameter int SYNC  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [29:0]          Addr,
    input  logic                 WE,
    input  logic [31:0]          Din,
    output logic [31:0]          Dout,
    input  logic [N_SRC-1:0]     irq_src,
    output logic [HWINT_W-1:0]   hwint,
    output logic                 irq
);

    logic [N_SRC-1:0]   r_mask;
    logic [N_SRC-1:0]   r_mode;
    logic [N_SRC-1:0]   w_pend;
    logic [N_SRC-1:0]   w_act;
    logic [N_SRC-1:0]   w_clr;
    logic               w_wr_pend;
    logic               w_wr_claim;
    logic [31:0]        w_claim_id;
    logic [HWINT_W-1:0] w_hwint;
    logic               w_unused;

    assign w_wr_pend  = WE && (Addr[1:0] == IRQ_PEND);
    assign w_wr_claim = WE && (Addr[1:0] == IRQ_CLAIM);
    assign w_unused   = ^Addr[29:2];

    // Clears only reach pend in edge mode; the cell ignores them for level sources.
    generate
        for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
            assign w_clr[gi] = (w_wr_pend && Din[gi]) ||
                               (w_wr_claim && (Din == claim_code(gi)));

            irq_src_cell #(
                .SYNC (SYNC)
            ) u_cell (
                .clk         (clk),
                .reset       (reset),
                .i_src       (irq_src[gi]),
                .i_edge_mode (r_mode[gi]),
                .i_clr       (w_clr[gi]),
                .o_pend      (w_pend[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mask <= '0;
            r_mode <= '0;
        end else if (WE) begin
            case (Addr[1:0])
                IRQ_MASK: r_mask <= Din[N_SRC-1:0];
                IRQ_MODE: r_mode <= Din[N_SRC-1:0];
                default:  ;
            endcase
        end
    end

    assign w_act = w_pend & r_mask;

    always_comb begin
        w_claim_id = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (w_act[i]) begin
                w_claim_id = claim_code(i);
            end
        end
    end

    always_comb begin
        w_hwint = '0;
        w_hwint[N_SRC-1:0] = w_act;
    end

    assign hwint = w_hwint;
    assign irq   = |w_act;

    always_comb begin
        Dout = '0;
        case (Addr[1:0])
            IRQ_PEND:  Dout[N_SRC-1:0] = w_pend;
            IRQ_MASK:  Dout[N_SRC-1:0] = r_mask;
            IRQ_MODE:  Dout[N_SRC-1:0] = r_mode;
            IRQ_CLAIM: Dout = w_claim_id;
            default:   Dout = '0;
        endcase
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: stimulus queues expected values, a negedge monitor
// pops and compares them against the DUT outputs.
module tb_irq_ctrl;
    import irq_ctrl_pkg::*;

    localparam int N_SRC = 3;

    logic               clk = 1'b0;
    logic               reset;
    logic [29:0]        Addr;
    logic               WE;
    logic [31:0]        Din;
    logic [31:0]        Dout;
    logic [N_SRC-1:0]   irq_src;
    logic [HWINT_W-1:0] hwint;
    logic               irq;

    always #5 clk = ~clk;

    irq_ctrl #(
        .N_SRC (N_SRC),
        .SYNC  (1)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .Addr    (Addr),
        .WE      (WE),
        .Din     (Din),
        .Dout    (Dout),
        .irq_src (irq_src),
        .hwint   (hwint),
        .irq     (irq)
    );

    typedef enum int {SEL_DOUT, SEL_HWINT, SEL_IRQ} sel_t;
    typedef struct {
        string       name;
        sel_t        sel;
        logic [31:0] val;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    exp_t        mon_e;
    logic [31:0] mon_act;

    // Monitor: everything queued since the last edge is compared mid-cycle.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            case (mon_e.sel)
                SEL_DOUT:  mon_act = Dout;
                SEL_HWINT: mon_act = {26'd0, hwint};
                default:   mon_act = {31'd0, irq};
            endcase
            n_checks++;
            if (mon_act !== mon_e.val) begin
                n_errors++;
                $display("FAIL %s: got %h, expected %h", mon_e.name, mon_act, mon_e.val);
            end else begin
                $display("ok   %s: %h", mon_e.name, mon_act);
            end
        end
    end

    function automatic void push(input string n, input sel_t s, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.sel  = s;
        e.val  = v;
        exp_q.push_back(e);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        $display("wr   reg %0d <= %h", a, d);
        Addr = {28'd0, a};
        Din  = d;
        WE   = 1'b1;
        tick();
        WE   = 1'b0;
        Din  = '0;
    endtask

    task automatic rd_chk(input string n, input logic [1:0] a, input logic [31:0] v);
        Addr = {28'd0, a};
        push(n, SEL_DOUT, v);
        tick();
    endtask

    task automatic out_chk(input string n, input logic [5:0] hw, input logic ir);
        push({n, ".hwint"}, SEL_HWINT, {26'd0, hw});
        push({n, ".irq"}, SEL_IRQ, {31'd0, ir});
        tick();
    endtask

    task automatic pulse(input int idx);
        irq_src[idx] = 1'b1;
        tick();
        irq_src[idx] = 1'b0;
    endtask

    initial begin
        reset   = 1'b0;
        Addr    = '0;
        WE      = 1'b0;
        Din     = '0;
        irq_src = '0;
        repeat (2) tick();
        out_chk("por", 6'd0, 1'b0);
        reset = 1'b1;
        rd_chk("por.pend", IRQ_PEND, 32'd0);
        rd_chk("por.claim", IRQ_CLAIM, 32'd0);

        // Level mode on source 0, two-cycle synchroniser latency each way.
        wr(IRQ_MASK, 32'h1);
        irq_src[SRC_TC0] = 1'b1;
        tick();
        out_chk("lvl.rise_k", 6'd0, 1'b0);
        out_chk("lvl.rise_k1", 6'd0, 1'b0);
        out_chk("lvl.rise_k2", 6'd1, 1'b1);
        wr(IRQ_PEND, 32'h1);
        rd_chk("lvl.w1c_noeffect", IRQ_PEND, 32'h1);
        out_chk("lvl.w1c_irq", 6'd1, 1'b1);
        irq_src[SRC_TC0] = 1'b0;
        tick();
        out_chk("lvl.fall_j", 6'd1, 1'b1);
        out_chk("lvl.fall_j1", 6'd1, 1'b1);
        out_chk("lvl.fall_j2", 6'd0, 1'b0);

        // Edge mode on source 1: a one-cycle pulse latches until claimed.
        wr(IRQ_MODE, 32'h2);
        wr(IRQ_MASK, 32'h2);
        pulse(SRC_TC1);
        tick();
        out_chk("edge.k1", 6'd0, 1'b0);
        out_chk("edge.k2", 6'd2, 1'b1);
        repeat (5) tick();
        out_chk("edge.held", 6'd2, 1'b1);
        rd_chk("edge.pend", IRQ_PEND, 32'h2);
        wr(IRQ_CLAIM, 32'd2);
        out_chk("edge.claimed", 6'd0, 1'b0);
        rd_chk("edge.pend_clr", IRQ_PEND, 32'h0);

        // Priority between simultaneous edges on sources 1 and 2.
        wr(IRQ_MODE, 32'h6);
        wr(IRQ_MASK, 32'h6);
        irq_src = 3'b110;
        tick();
        irq_src = 3'b000;
        repeat (3) tick();
        rd_chk("prio.claim_2", IRQ_CLAIM, 32'd2);
        wr(IRQ_CLAIM, 32'd7);
        rd_chk("prio.bad_claim", IRQ_CLAIM, 32'd2);
        wr(IRQ_CLAIM, 32'd2);
        rd_chk("prio.claim_3", IRQ_CLAIM, 32'd3);
        wr(IRQ_CLAIM, 32'd3);
        rd_chk("prio.claim_0", IRQ_CLAIM, 32'd0);
        rd_chk("prio.pend", IRQ_PEND, 32'd0);

        // New rising edge on the same edge as a W1C: set wins.
        wr(IRQ_MODE, 32'h7);
        wr(IRQ_MASK, 32'h1);
        pulse(SRC_TC0);
        repeat (3) tick();
        rd_chk("setclr.pre", IRQ_PEND, 32'h1);
        irq_src[SRC_TC0] = 1'b1;
        tick();
        irq_src[SRC_TC0] = 1'b0;
        tick();
        wr(IRQ_PEND, 32'h1);
        rd_chk("setclr.set_wins", IRQ_PEND, 32'h1);
        out_chk("setclr.out", 6'd1, 1'b1);
        wr(IRQ_PEND, 32'h1);
        rd_chk("setclr.w1c", IRQ_PEND, 32'h0);

        // Masked pend is latched but invisible until unmasked.
        wr(IRQ_MASK, 32'h0);
        pulse(SRC_EXT);
        repeat (3) tick();
        rd_chk("mask.pend", IRQ_PEND, 32'h4);
        out_chk("mask.off", 6'd0, 1'b0);
        rd_chk("mask.claim0", IRQ_CLAIM, 32'd0);
        wr(IRQ_MASK, 32'h4);
        out_chk("mask.on", 6'd4, 1'b1);
        rd_chk("mask.rd", IRQ_MASK, 32'h4);
        rd_chk("mask.claim3", IRQ_CLAIM, 32'd3);

        // Reset asserted mid-run with pend=101, mask=111.
        wr(IRQ_MASK, 32'hFFFF_FFFF);
        rd_chk("rst.mask_upper0", IRQ_MASK, 32'h7);
        pulse(SRC_TC0);
        repeat (3) tick();
        rd_chk("rst.pre_pend", IRQ_PEND, 32'h5);
        out_chk("rst.pre_out", 6'd5, 1'b1);
        reset = 1'b0;
        #1;
        out_chk("rst.async", 6'd0, 1'b0);
        rd_chk("rst.pend_in", IRQ_PEND, 32'h0);
        reset = 1'b1;
        rd_chk("rst.pend", IRQ_PEND, 32'h0);
        rd_chk("rst.mask", IRQ_MASK, 32'h0);
        rd_chk("rst.mode", IRQ_MODE, 32'h0);
        rd_chk("rst.claim", IRQ_CLAIM, 32'h0);
        out_chk("rst.out", 6'd0, 1'b0);

        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending checks, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
